// File: rtl/shift_unit_iterative_pkg.sv
// Shared encodings for the iterative shift unit: operation codes and FSM states.
package shift_pkg;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/shift_unit_iterative_if.sv
// Request/response handshake bundle between a client and the iterative shift unit.
interface shift_unit_iterative_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   operand;
    logic [SHAMT_W-1:0] shamt;
    logic [1:0]         op;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   result;

    modport master (
        output in_valid, operand, shamt, op, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, operand, shamt, op, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/shift_unit_iterative_shift_step.sv
// Combinational single-step shifter: moves a WIDTH value by 0..STEP bits in one of four modes.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AMT_W = 6
) (
    input  logic [WIDTH-1:0] data,
    input  logic [AMT_W-1:0] amt,
    input  logic [1:0]       op,
    input  logic             sign,
    output logic [WIDTH-1:0] shifted
);
    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

    // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
    always_comb begin
        shifted = '0;
        case (op)
            OP_SLL:  shifted = data << amt;
            OP_SRL:  shifted = data >> amt;
            // Fill comes from the sign captured at accept, not from the partially shifted data.
            OP_SRA:  shifted = (data >> amt) | (~(ONES >> amt) & {WIDTH{sign}});
            default: shifted = (data >> amt) | (data << (WIDTH - int'(amt)));
        endcase
    end

endmodule

// File: rtl/shift_unit_iterative.sv
// Multi-cycle shifter: accepts one request, shifts up to STEP bits per clock, then holds the
// result until the consumer takes it. Flush aborts synchronously; reset_n aborts asynchronously.
module shift_unit_iterative
    import shift_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH),
    parameter int STEP    = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    output logic                   busy,
    shift_unit_iterative_if.slave  bus
);
    localparam int AMT_W = SHAMT_W + 1;
    localparam logic [AMT_W-1:0] STEP_V = AMT_W'(STEP);

    if (STEP < 1 || STEP > WIDTH) begin : g_step_range
        $fatal(1, "shift_unit_iterative: STEP must lie in 1..WIDTH");
    end

    logic [1:0]         state;
    logic [WIDTH-1:0]   data;
    logic [SHAMT_W-1:0] remaining;
    logic [1:0]         op_q;
    logic               sign_q;
    logic [AMT_W-1:0]   step_amt;
    logic               last_step;
    logic [WIDTH-1:0]   next_data;

    assign last_step = ({1'b0, remaining} <= STEP_V);
    assign step_amt  = last_step ? {1'b0, remaining} : STEP_V;

    shift_step #(
        .WIDTH (WIDTH),
        .AMT_W (AMT_W)
    ) u_step (
        .data    (data),
        .amt     (step_amt),
        .op      (op_q),
        .sign    (sign_q),
        .shifted (next_data)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            data      <= '0;
            remaining <= '0;
            op_q      <= OP_SLL;
            sign_q    <= 1'b0;
        end else if (flush) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        data      <= bus.operand;
                        remaining <= bus.shamt;
                        op_q      <= bus.op;
                        sign_q    <= bus.operand[WIDTH-1];
                        state     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    data      <= next_data;
                    remaining <= remaining - step_amt[SHAMT_W-1:0];
                    if (last_step) state <= ST_DONE;
                end
                ST_DONE: begin
                    if (bus.out_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // The data register drives result directly, so it cannot glitch while DONE holds.
    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.result    = data;
    assign busy          = (state != ST_IDLE);

endmodule

// File: tb/tb_shift_unit_iterative.sv
// Directed bench for shift_unit_iterative: modes, latency, back-pressure, flush and async reset.
module tb_shift_unit_iterative;
    import shift_pkg::*;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;
    localparam int STEP    = 4;

    logic clk = 1'b0;
    logic reset_n;
    logic flush;
    logic busy;
    int   checks = 0;
    int   errors = 0;
    int   lat;

    shift_unit_iterative_if #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) bus ();

    shift_unit_iterative #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W),
        .STEP    (STEP)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .busy    (busy),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [1:0] op, input logic [31:0] a, input logic [4:0] s);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.operand  = a;
        bus.shamt    = s;
        tick();
        bus.in_valid = 1'b0;
        bus.operand  = 32'hDEAD_BEEF;
        bus.shamt    = 5'd17;
    endtask

    task automatic wait_valid(input int max, output int n);
        n = 0;
        while (!bus.out_valid && n < max) begin
            tick();
            n++;
        end
    endtask

    task automatic consume(input string tag);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({tag, "_drop"}, {31'd0, bus.out_valid}, 32'd0);
    endtask

    task automatic run(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [4:0] s, input int exp_lat, input logic [31:0] exp_res);
        int n;
        accept(op, a, s);
        wait_valid(20, n);
        check({tag, "_lat"}, 32'(n), 32'(exp_lat));
        check({tag, "_res"}, bus.result, exp_res);
        consume(tag);
    endtask

    initial begin
        reset_n       = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.operand   = '0;
        bus.shamt     = '0;
        bus.op        = OP_SLL;
        #1;
        check("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_busy",      {31'd0, busy},          32'd0);
        check("rst_result",    bus.result,             32'd0);
        #20 reset_n = 1'b1;
        tick();

        // Mode and latency coverage.
        run("sll_2",   OP_SLL, 32'h0000_0001, 5'd2,  1, 32'h0000_0004);
        run("sra_31",  OP_SRA, 32'h8000_0000, 5'd31, 8, 32'hFFFF_FFFF);
        run("srl_31",  OP_SRL, 32'h8000_0000, 5'd31, 8, 32'h0000_0001);
        run("ror_5",   OP_ROR, 32'h0000_00F1, 5'd5,  2, 32'h8800_0007);
        run("ror_0",   OP_ROR, 32'h0000_00F1, 5'd0,  1, 32'h0000_00F1);
        run("sll_4",   OP_SLL, 32'h0000_0001, 5'd4,  1, 32'h0000_0010);
        run("sll_5",   OP_SLL, 32'h0000_0001, 5'd5,  2, 32'h0000_0020);
        run("sra_pos", OP_SRA, 32'h7000_0000, 5'd9,  3, 32'h0038_0000);

        // Back-pressure in DONE: result stable, new requests ignored.
        accept(OP_SRL, 32'h0000_00F0, 5'd3);
        wait_valid(20, lat);
        check("hold_lat", 32'(lat), 32'd1);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.operand  = 32'h1234_5678 + 32'(i);
            bus.shamt    = 5'd1;
            bus.op       = OP_SLL;
            tick();
            check("hold_valid", {31'd0, bus.out_valid}, 32'd1);
            check("hold_res",   bus.result,             32'h0000_001E);
            check("hold_ready", {31'd0, bus.in_ready},  32'd0);
        end
        // Out_ready together with in_valid: the request waits one cycle in IDLE.
        bus.operand   = 32'h0000_0003;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("simul_idle",  {31'd0, bus.in_ready},  32'd1);
        check("simul_noval", {31'd0, bus.out_valid}, 32'd0);
        tick();
        bus.in_valid = 1'b0;
        check("simul_acc", {31'd0, busy}, 32'd1);
        wait_valid(20, lat);
        check("simul_lat", 32'(lat), 32'd1);
        check("simul_res", bus.result, 32'h0000_0006);
        consume("simul");

        // Flush in the second SHIFT cycle of a long shift.
        accept(OP_SLL, 32'h0000_0001, 5'd20);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_idle", {31'd0, bus.in_ready}, 32'd1);
        check("flush_busy", {31'd0, busy},         32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("flush_noval", {31'd0, bus.out_valid}, 32'd0);
        end
        run("post_flush", OP_SRA, 32'h8000_0000, 5'd1, 1, 32'hC000_0000);

        // Flush beats a request in IDLE.
        flush        = 1'b1;
        bus.in_valid = 1'b1;
        bus.operand  = 32'h0000_0001;
        bus.shamt    = 5'd1;
        tick();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_noacc", {31'd0, busy}, 32'd0);

        // Flush beats out_ready in DONE.
        accept(OP_SLL, 32'h0000_0001, 5'd1);
        wait_valid(20, lat);
        check("flush_done_lat", 32'(lat), 32'd1);
        flush         = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        flush         = 1'b0;
        bus.out_ready = 1'b0;
        check("flush_done_val", {31'd0, bus.out_valid}, 32'd0);
        check("flush_done_rdy", {31'd0, bus.in_ready},  32'd1);

        // Asynchronous reset mid-SHIFT, away from any clock edge.
        accept(OP_SLL, 32'h0000_FFFF, 5'd20);
        tick();
        tick();
        #2 reset_n = 1'b0;
        #1;
        check("arst_in_ready",  {31'd0, bus.in_ready},  32'd1);
        check("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("arst_busy",      {31'd0, busy},          32'd0);
        check("arst_result",    bus.result,             32'd0);
        #3 reset_n = 1'b1;
        tick();
        run("post_rst", OP_SLL, 32'h0000_0001, 5'd31, 8, 32'h8000_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_unit_iterative.md
Name: shift_unit_iterative

Overview:
- Parametrised multi-cycle shifter; successor to the fixed combinational shift-left-by-2 used for branch offsets.
- Supports variable shift amount and four shift modes. Shifts up to STEP bits per clock.
- Valid/ready handshake on both sides, so it can sit behind the EX stage as a shared shift resource or be used for address and offset generation.

Parameters:
- WIDTH, 32, operand/result width in bits.
- SHAMT_W, $clog2(WIDTH) = 5, shift-amount width. Legal amounts are 0..WIDTH-1.
- STEP, 4, maximum bits shifted per clock. Legal range is 1..WIDTH; elaboration must fail outside it.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Flush  in  1  synchronous abort; returns to IDLE and drops any in-flight operation.
- In_Valid  in  1  request present.
- In_Ready  out  1  unit can accept a request.
- Operand  in  WIDTH  data to shift.
- Shamt  in  SHAMT_W  shift amount.
- Op  in  2  mode: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
- Out_Valid  out  1  Result valid.
- Out_Ready  in  1  consumer accepts Result.
- Result  out  WIDTH  shifted value.
- Busy  out  1  high in SHIFT or DONE.

Behaviour:
- Reset (async, Reset_n=0):
  - State is IDLE.
  - In_Ready=1, Out_Valid=0, Busy=0, Result=0.
  - Internal remaining count and op are cleared.
  - Reset may assert in any state; the operation is lost.
- States and transitions:
  - IDLE: In_Ready=1. On In_Valid&&In_Ready, latch Operand, Shamt (as remaining) and Op, then go to SHIFT.
  - SHIFT: each clock, step = min(remaining, STEP). Shift the data register by step per Op and set remaining -= step. If remaining <= STEP at this edge, go to DONE.
  - DONE: Out_Valid=1 and Result holds the data register, stable while Out_Ready=0. On Out_Ready, go to IDLE and drop Out_Valid on the next cycle.
- Latency:
  - Accept edge to Out_Valid is max(1, ceil(Shamt/STEP)) clocks.
  - Shamt=0 costs one SHIFT cycle with step 0; Result equals Operand.
- Arithmetic rules:
  - SLL: zero-fill.
  - SRL: zero-fill.
  - SRA: replicate the latched operand MSB. The sign is taken at accept and is unchanged by partial steps.
  - ROR: bits leaving the LSB re-enter at the MSB.
  - All arithmetic is modulo WIDTH; no overflow flag.
- Handshake:
  - In_Ready is 0 in SHIFT and DONE, so no back-to-back accept while DONE is occupied.
  - Input signals are ignored when In_Valid=0 or In_Ready=0.
  - Result is don't-care when Out_Valid=0, but must not glitch while Out_Valid=1.
- Flush:
  - Flush=1 forces IDLE at the next edge from any state and clears Out_Valid.
  - Flush has priority over Out_Ready and In_Valid. A request presented in IDLE with Flush=1 is not accepted.
- Simultaneous events:
  - Out_Ready in DONE with In_Valid high: the request is not accepted this cycle. It is accepted the following cycle in IDLE.

Decomposition:
- Shared package shift_pkg holds:
  - Op encodings (OP_SLL=2'b00, OP_SRL=2'b01, OP_SRA=2'b10, OP_ROR=2'b11).
  - State encoding (IDLE, SHIFT, DONE).
- One natural sub-module, shift_step:
  - Combinational; shifts a WIDTH value by 0..STEP bits per Op.
  - Instantiated once in the datapath.
  - The FSM, counter and handshake stay in shift_unit_iterative.

Test Plan:
- SLL, Operand=0x0000_0001, Shamt=2, STEP=4 -> Out_Valid one clock after accept; Result=0x0000_0004. This matches the legacy branch-offset shifter.
- SRA, Operand=0x8000_0000, Shamt=31 -> Out_Valid eight clocks after accept; Result=0xFFFF_FFFF. SRL with the same inputs -> Result=0x0000_0001.
- ROR, Operand=0x0000_00F1, Shamt=5 -> two SHIFT cycles; Result=0x8800_0007. Shamt=0 -> one cycle; Result=Operand.
- Out_Ready held low for 5 clocks in DONE -> Out_Valid and Result stable. In_Ready=0 throughout; In_Valid pulses are ignored.
- Flush asserted in the second SHIFT cycle of Shamt=20 -> IDLE next edge, Out_Valid never rises, next request Shamt=1 completes correctly.
- Reset_n pulled low asynchronously mid-SHIFT -> outputs go to reset values immediately without waiting for Clk. After release, a new SLL Shamt=31 of 0x1 -> 0x8000_0000.
